rijndael_round_controller: RTL and testbench

- Sequences one Rijndael block operation across the shared key-schedule and round datapath.
- Accepts a key/block job through a valid/ready handshake, then pulses the key-schedule load.
- Steps the key schedule and round datapath through NR+1 round-key applications, then holds the result until the consumer accepts it.
- Sits between the top-level stream interface and the key-schedule and round datapath instances.

---
 rtl/rijndael_pkg.sv | 28 ++
 rtl/rijndael_round_controller.sv | 121 ++++++++++++
 tb/tb_rijndael_round_controller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rijndael_pkg.sv
// -----------------------------------------------------------------------------
// rijndael_pkg
// Shared types and helpers for the Rijndael round controller.
//   round_type_e : kind of round applied by the round datapath in a cycle
//   ctrl_state_e : controller FSM states
//   num_rounds() : round count for a given block/key size in 32-bit words
// -----------------------------------------------------------------------------
package rijndael_pkg;

    typedef enum logic [1:0] {
        ROUND_INIT  = 2'd0,  // initial AddRoundKey only
        ROUND_FULL  = 2'd1,  // SubBytes, ShiftRows, MixColumns, AddRoundKey
        ROUND_FINAL = 2'd2   // as a full round but without MixColumns
    } round_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    // Rijndael uses max(Nb, Nk) + 6 rounds.
    function automatic int num_rounds(input int nb, input int nk);
        return ((nb > nk) ? nb : nk) + 6;
    endfunction

endpackage : rijndael_pkg

// File: rtl/rijndael_round_controller.sv
// -----------------------------------------------------------------------------
// rijndael_round_controller
// Sequences one Rijndael block operation over the shared key schedule and
// round datapath: accept a job, load both units, apply NR+1 round keys, then
// hold the result until the consumer takes it.
//
// Parameters
//   NB, NK        block / key size in 32-bit words (4, 6 or 8)
//   NR, CNTW      derived round count and round-counter width
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o       job handshake (key/block presented outside)
//   out_valid_o / out_ready_i     result handshake
//   ks_load_o, ks_enable_o        key schedule capture / advance one round key
//   dp_load_o, dp_enable_o        round datapath capture / apply one round
//   round_type_o                  0 initial AddRoundKey, 1 full, 2 final round
//   round_cnt_o                   current round index
//   busy_o                        controller not idle
//   abort_i                       abort request (only with the macro below)
//
// Build option
//   RIJNDAEL_CTRL_ABORT_EN : when defined, abort_i in LOAD or ROUND returns the
//   controller to IDLE on the next edge without presenting a result. When
//   undefined, abort_i is ignored and a started job always completes.
// -----------------------------------------------------------------------------
module rijndael_round_controller
    import rijndael_pkg::*;
#(
    parameter  int NB   = 4,
    parameter  int NK   = 4,
    localparam int NR   = num_rounds(NB, NK),
    localparam int CNTW = $clog2(NR + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            ks_load_o,
    output logic            ks_enable_o,
    output logic            dp_load_o,
    output logic            dp_enable_o,
    output logic [1:0]      round_type_o,
    output logic [CNTW-1:0] round_cnt_o,
    output logic            busy_o,
    input  logic            abort_i
);

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NR);

    ctrl_state_e     state_q;
    logic [CNTW-1:0] cnt_q;
    logic            abort_req;
    round_type_e     round_type;

`ifdef RIJNDAEL_CTRL_ABORT_EN
    // Abort only has an effect while a job is in flight; IDLE and DONE ignore it.
    assign abort_req = abort_i && ((state_q == ST_LOAD) || (state_q == ST_ROUND));
`else
    logic unused_abort;
    assign unused_abort = abort_i;
    assign abort_req    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (abort_req) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the registered state and counter only, so
    // they fall to their idle values as soon as reset is asserted.
    assign in_ready_o  = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign ks_load_o   = (state_q == ST_LOAD);
    assign dp_load_o   = (state_q == ST_LOAD);
    assign dp_enable_o = (state_q == ST_ROUND);
    // The key schedule advances after each key use, except after the last one.
    assign ks_enable_o = (state_q == ST_ROUND) && (cnt_q != LAST_CNT);
    assign round_cnt_o = cnt_q;

    assign round_type = (state_q != ST_ROUND) ? ROUND_INIT  :
                        (cnt_q == '0)         ? ROUND_INIT  :
                        (cnt_q == LAST_CNT)   ? ROUND_FINAL : ROUND_FULL;
    assign round_type_o = round_type;

endmodule : rijndael_round_controller

// File: tb/tb_rijndael_round_controller.sv
// -----------------------------------------------------------------------------
// tb_rijndael_round_controller
// Directed bench for rijndael_round_controller. Four instances share stimulus:
// index 0 is NB=NK=4 (NR=10), then NK=6, NK=8 and NB=8 variants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rijndael_round_controller;

    localparam int NDUT = 4;
    localparam int NB_T [NDUT] = '{4, 4, 4, 8};
    localparam int NK_T [NDUT] = '{4, 6, 8, 4};
    // Hand-computed: NR = 10/12/14/14, latency NR+3, NR key-schedule advances.
    localparam int EXP_LAT [NDUT] = '{13, 15, 17, 17};
    localparam int EXP_KSE [NDUT] = '{10, 12, 14, 14};

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic abort;

    logic [NDUT-1:0] in_ready, out_valid, ks_load, ks_enable;
    logic [NDUT-1:0] dp_load, dp_enable, busy;
    logic [1:0]      rtype [NDUT];
    logic [3:0]      rcnt  [NDUT];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        rijndael_round_controller #(.NB(NB_T[g]), .NK(NK_T[g])) u_dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .in_valid_i   (in_valid),
            .in_ready_o   (in_ready[g]),
            .out_valid_o  (out_valid[g]),
            .out_ready_i  (out_ready),
            .ks_load_o    (ks_load[g]),
            .ks_enable_o  (ks_enable[g]),
            .dp_load_o    (dp_load[g]),
            .dp_enable_o  (dp_enable[g]),
            .round_type_o (rtype[g]),
            .round_cnt_o  (rcnt[g]),
            .busy_o       (busy[g]),
            .abort_i      (abort)
        );
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are observed 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        abort     = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Present one job for a single accepting edge (DUT 0 must be idle).
    task automatic start_job();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Cycles since start_job() until DUT 0 shows out_valid; -1 on timeout.
    task automatic wait_out(input int already, output int lat);
        lat = -1;
        for (int c = already; c <= 40; c++) begin
            if (out_valid[0]) begin
                lat = c;
                break;
            end
            step();
        end
    endtask

    initial begin
        int lat;
        int lat_m  [NDUT];
        int kse_m  [NDUT];
        int clash;
        int acc_n, cmp_n, last_acc, bad_gap;

        do_reset();

        // ---- reset state ------------------------------------------------
        check("rst_in_ready",  in_ready[0],  1);
        check("rst_out_valid", out_valid[0], 0);
        check("rst_busy",      busy[0],      0);
        check("rst_round_cnt", rcnt[0],      0);
        check("rst_round_type", rtype[0],    0);

        // ---- single job, NR=10: detailed sequence -------------------------
        start_job();
        check("load_ks_load",   ks_load[0],   1);
        check("load_dp_load",   dp_load[0],   1);
        check("load_ks_enable", ks_enable[0], 0);
        check("load_in_ready",  in_ready[0],  0);
        begin
            int kse = 0;
            int bad_type = 0, bad_cnt = 0, bad_dpe = 0, bad_kse = 0;
            for (int i = 0; i <= 10; i++) begin
                int exp_t;
                step();
                exp_t = (i == 0) ? 0 : ((i == 10) ? 2 : 1);
                if (rtype[0] != 2'(exp_t)) bad_type++;
                if (rcnt[0] != 4'(i))      bad_cnt++;
                if (!dp_enable[0] || dp_load[0]) bad_dpe++;
                if (ks_enable[0] != (i < 10) || ks_load[0]) bad_kse++;
                if (ks_enable[0]) kse++;
            end
            check("round_type_seq", bad_type, 0);
            check("round_cnt_seq",  bad_cnt,  0);
            check("dp_enable_seq",  bad_dpe,  0);
            check("ks_enable_seq",  bad_kse,  0);
            check("ks_enable_cnt",  kse,      10);
        end
        step();
        check("done_out_valid", out_valid[0], 1);
        check("done_round_cnt", rcnt[0],      0);
        step();
        check("ret_idle", in_ready[0], 1);

        // ---- all four parameterisations ----------------------------------
        do_reset();
        clash = 0;
        for (int d = 0; d < NDUT; d++) begin
            lat_m[d] = 0;
            kse_m[d] = 0;
        end
        start_job();
        for (int c = 1; c <= 30; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (ks_enable[d]) kse_m[d]++;
                if ((ks_load[d] && ks_enable[d]) || (dp_load[d] && dp_enable[d])) clash++;
                if (out_valid[d] && lat_m[d] == 0) lat_m[d] = c;
            end
            step();
        end
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("latency_dut%0d", d), lat_m[d], EXP_LAT[d]);
            check($sformatf("ks_enables_dut%0d", d), kse_m[d], EXP_KSE[d]);
        end
        check("load_enable_clash", clash, 0);

        // ---- consumer back-pressure in DONE ------------------------------
        do_reset();
        out_ready = 1'b0;
        start_job();
        wait_out(1, lat);
        check("bp_latency", lat, 13);
        begin
            int held = 0, rdy = 0;
            for (int k = 0; k < 5; k++) begin
                if (out_valid[0]) held++;
                if (in_ready[0])  rdy++;
                step();
            end
            if (out_valid[0]) held++;
            if (in_ready[0])  rdy++;
            check("bp_valid_held", held, 6);
            check("bp_in_ready_low", rdy, 0);
        end
        out_ready = 1'b1;
        step();
        check("bp_released_valid", out_valid[0], 0);
        check("bp_released_ready", in_ready[0],  1);

        // ---- continuous in_valid: initiation interval --------------------
        do_reset();
        in_valid = 1'b1;
        acc_n = 0; cmp_n = 0; last_acc = -1; bad_gap = 0;
        for (int c = 0; c < 60; c++) begin
            if (in_ready[0]) begin
                if (last_acc >= 0 && c - last_acc != 14) bad_gap++;
                last_acc = c;
                acc_n++;
            end
            if (out_valid[0] && out_ready) cmp_n++;
            step();
        end
        in_valid = 1'b0;
        check("b2b_accepts",     acc_n,   5);
        check("b2b_completions", cmp_n,   4);
        check("b2b_interval",    bad_gap, 0);

        // ---- reset mid-operation -----------------------------------------
        do_reset();
        start_job();
        begin
            int found = 0;
            for (int c = 0; c < 20; c++) begin
                if (busy[0] && dp_enable[0] && rcnt[0] == 4'd5) begin
                    found = 1;
                    break;
                end
                step();
            end
            check("mid_reached_cnt5", found, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  in_ready[0],  1);
        check("mid_rst_busy",      busy[0],      0);
        check("mid_rst_dp_enable", dp_enable[0], 0);
        check("mid_rst_ks_enable", ks_enable[0], 0);
        check("mid_rst_round_cnt", rcnt[0],      0);
        check("mid_rst_out_valid", out_valid[0], 0);
        step();
        rst_n = 1'b1;
        step();
        start_job();
        wait_out(1, lat);
        check("post_rst_latency", lat, 13);
        step();

        // ---- abort at round_cnt 3 ----------------------------------------
        do_reset();
        start_job();
        for (int c = 1; c < 5; c++) step();
        check("abort_at_cnt3", rcnt[0], 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
`ifdef RIJNDAEL_CTRL_ABORT_EN
        check("abort_idle",     in_ready[0], 1);
        check("abort_cnt_zero", rcnt[0],     0);
        begin
            int seen = 0;
            for (int c = 0; c < 20; c++) begin
                if (out_valid[0]) seen++;
                step();
            end
            check("abort_no_result", seen, 0);
        end
`else
        check("noabort_still_busy", busy[0], 1);
        check("noabort_cnt", rcnt[0], 4);
        wait_out(6, lat);
        check("noabort_latency", lat, 13);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rijndael_round_controller
